fm_freeze_ctrl: RTL and testbench
=================================

# fm_freeze_ctrl

Per-spybuffer freeze controller that sits directly upstream of the fast-monitor spybuffer array. It registers one monitored ULT data stream, forwards it to the spybuffer write port, and arms, triggers and holds that spybuffer's freeze line. A pattern match or forced trigger starts a programmable post-trigger capture window. One instance is built per spybuffer, so `total_sb` instances feed the `freeze[total_sb]` vector.

## Interface

Parameters:
- DATA_WIDTH, 256, monitored word width; equals the spybuffer write width.
- TRIG_WIDTH, 32, compared slice `in_data[TRIG_WIDTH-1:0]`.
- CNT_WIDTH, 16, post-trigger counter width.
- TS_WIDTH, 32, timestamp width.

Ports:
- clk_hs  in  1  high-speed clock; the only clock.
- rst_hs_bar  in  1  reset, asynchronous, active-low.
- in_data  in  DATA_WIDTH  monitored data.
- in_vld  in  1  in_data valid.
- arm  in  1  pulse; arm trigger.
- force_trig  in  1  pulse; unconditional trigger.
- release_frz  in  1  pulse; release or abort.
- trig_value  in  TRIG_WIDTH  match value.
- trig_mask  in  TRIG_WIDTH  1 = bit compared.
- post_trig_cnt  in  CNT_WIDTH  valid words captured after the trigger word.
- fm_data  out  DATA_WIDTH  to spybuffer write_data.
- fm_vld  out  1  to spybuffer write_enable.
- freeze  out  1  to spybuffer freeze.
- state  out  2  FSM state.
- trig_ts  out  TS_WIDTH  timestamp latched at trigger.

## Operation

- Data path:
  - `fm_data`/`fm_vld` are `in_data`/`in_vld` registered once.
  - Data is forwarded in every state; the spybuffer itself gates writes with `freeze`.
- Match condition: `in_vld && (((in_data[TRIG_WIDTH-1:0] ^ trig_value) & trig_mask) == 0)`.
  - With `trig_mask = 0`, any valid word matches.
- Trigger event (`trig`): `force_trig`, or the match condition, sampled only in ARMED.
- FSM (`state` encoding):
  - IDLE (00): `arm` → ARMED.
  - ARMED (01): on `trig`, if `post_trig_cnt == 0` → FROZEN; otherwise load `remain = post_trig_cnt` → POST.
  - POST (10): each `in_vld` decrements `remain`; `in_vld` with `remain == 1` → FROZEN.
    - The trigger word is not counted.
  - FROZEN (11): `release_frz` → IDLE.
  - In ARMED or POST: `release_frz` aborts → IDLE, and `freeze` is never raised.
- Priority: `release_frz` > `trig` > `arm`.
  - `arm` outside IDLE is ignored.
  - `force_trig` outside ARMED is ignored.
- `post_trig_cnt` is sampled only on the trigger cycle; later changes do not affect an active window.
- `freeze` is a register set from `state == FROZEN`.

## Timing

- Reset values: `fm_data` = 0, `fm_vld` = 0, `freeze` = 0, `state` = IDLE, `trig_ts` = 0, `remain` = 0, timestamp counter = 0.
- Data latency: 1 cycle, in → fm.
- State transitions complete on the edge that samples the causing input.
- `freeze` rises one cycle after `state` becomes FROZEN.
  - Result: the last counted word is on `fm_vld` exactly one cycle before `freeze` = 1, so the spybuffer captures it.
- `freeze` falls one cycle after `state` leaves FROZEN.
- `trig_ts` latches the free-running counter value on the trigger edge.
  - The counter wraps modulo 2^TS_WIDTH.
  - `trig_ts` holds until the next trigger.
- Simultaneous `trig` and `release_frz` in ARMED → IDLE; `trig_ts` is not updated.
- `remain` never underflows; it is only decremented in POST while ≥ 1.
- Reset asserted mid-window: immediate return to reset values, with `freeze` dropping asynchronously.

## Configuration

- `FM_FREEZE_TS_EN` defined: timestamp counter and `trig_ts` latch are implemented as above.
- Undefined: counter and latch are removed and `trig_ts` is tied to 0. FSM, data path and `freeze` are unchanged.

## Test plan

- Reset held, then released with `in_vld` toggling → all outputs 0 during reset; afterwards `fm_vld` follows `in_vld` one cycle later and `state` = 00.
- Arm, `trig_mask` = 0x0000_00FF, `trig_value` = 0x0000_00A5, `post_trig_cnt` = 3, word 0x..A5 followed by 5 valid words → POST after the match; FROZEN after the 3rd valid word; `freeze` = 1 one cycle after the 3rd post word appears on `fm_vld`.
- Arm with `post_trig_cnt` = 0, then `force_trig` → ARMED→FROZEN in one edge; `freeze` the next cycle; `release_frz` → IDLE, `freeze` = 0 one cycle later.
- In POST with `remain` = 2, pulse `release_frz` together with `in_vld` → IDLE; `freeze` never asserted.
- In ARMED, matching word with `release_frz` in the same cycle → IDLE; `trig_ts` unchanged; `arm` in FROZEN is ignored.
- With `FM_FREEZE_TS_EN`: trigger 100 cycles after reset release → `trig_ts` = 100. Without the macro → `trig_ts` = 0 throughout.

Source files
------------

// File: rtl/fm_freeze_ctrl.sv
// Spybuffer freeze controller: registers one ULT stream, arms/triggers/holds freeze; FM_FREEZE_TS_EN adds trigger timestamp.
// Latency 1 cycle in->fm; no backpressure (the spybuffer gates its own writes with freeze).
module fm_freeze_ctrl #(
  parameter int DATA_WIDTH = 256,
  parameter int TRIG_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int TS_WIDTH   = 32
) (
  input  logic                  clk_hs,
  input  logic                  rst_hs_bar,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_vld,
  input  logic                  arm,
  input  logic                  force_trig,
  input  logic                  release_frz,
  input  logic [TRIG_WIDTH-1:0] trig_value,
  input  logic [TRIG_WIDTH-1:0] trig_mask,
  input  logic [CNT_WIDTH-1:0]  post_trig_cnt,
  output logic [DATA_WIDTH-1:0] fm_data,
  output logic                  fm_vld,
  output logic                  freeze,
  output logic [1:0]            state,
  output logic [TS_WIDTH-1:0]   trig_ts
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ARMED  = 2'b01,
    POST   = 2'b10,
    FROZEN = 2'b11
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] remain_q, remain_d;
  logic                 match;
  logic                 trig;
  logic                 trig_take;

  assign match     = in_vld && (((in_data[TRIG_WIDTH-1:0] ^ trig_value) & trig_mask) == '0);
  assign trig      = (state_q == ARMED) && (force_trig || match);
  // A release in the same cycle wins over the trigger, so nothing is latched.
  assign trig_take = trig && !release_frz;

  always_ff @(posedge clk_hs or negedge rst_hs_bar) begin
    if (!rst_hs_bar) begin
      fm_data  <= '0;
      fm_vld   <= 1'b0;
      freeze   <= 1'b0;
      state_q  <= IDLE;
      remain_q <= '0;
    end else begin
      fm_data  <= in_data;
      fm_vld   <= in_vld;
      freeze   <= (state_q == FROZEN);
      state_q  <= state_d;
      remain_q <= remain_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    case (state_q)
      IDLE: begin
        if (!release_frz && arm) state_d = ARMED;
      end
      ARMED: begin
        if (release_frz) begin
          state_d = IDLE;
        end else if (trig) begin
          if (post_trig_cnt == '0) begin
            state_d = FROZEN;
          end else begin
            remain_d = post_trig_cnt;
            state_d  = POST;
          end
        end
      end
      POST: begin
        if (release_frz) begin
          state_d  = IDLE;
          remain_d = '0;
        end else if (in_vld && remain_q != '0) begin
          remain_d = remain_q - CNT_WIDTH'(1);
          if (remain_q == CNT_WIDTH'(1)) state_d = FROZEN;
        end
      end
      FROZEN: begin
        if (release_frz) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign state = state_q;

`ifdef FM_FREEZE_TS_EN
  logic [TS_WIDTH-1:0] ts_cnt;

  always_ff @(posedge clk_hs or negedge rst_hs_bar) begin
    if (!rst_hs_bar) begin
      ts_cnt  <= '0;
      trig_ts <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_WIDTH'(1);
      if (trig_take) trig_ts <= ts_cnt;
    end
  end
`else
  assign trig_ts = '0;
`endif

endmodule

// File: tb/tb_fm_freeze_ctrl.sv
// Directed bench for fm_freeze_ctrl; expectations hand-derived, trig_ts checked for both builds.
module tb_fm_freeze_ctrl;

  logic         clk_hs;
  logic         rst_hs_bar;
  logic [255:0] in_data;
  logic         in_vld;
  logic         arm;
  logic         force_trig;
  logic         release_frz;
  logic [31:0]  trig_value;
  logic [31:0]  trig_mask;
  logic [15:0]  post_trig_cnt;
  logic [255:0] fm_data;
  logic         fm_vld;
  logic         freeze;
  logic [1:0]   state;
  logic [31:0]  trig_ts;

  int pass_cnt;
  int total_cnt;
  int unsigned cyc;
  logic [31:0] exp_ts;

  fm_freeze_ctrl dut (
    .clk_hs        (clk_hs),
    .rst_hs_bar    (rst_hs_bar),
    .in_data       (in_data),
    .in_vld        (in_vld),
    .arm           (arm),
    .force_trig    (force_trig),
    .release_frz   (release_frz),
    .trig_value    (trig_value),
    .trig_mask     (trig_mask),
    .post_trig_cnt (post_trig_cnt),
    .fm_data       (fm_data),
    .fm_vld        (fm_vld),
    .freeze        (freeze),
    .state         (state),
    .trig_ts       (trig_ts)
  );

  initial clk_hs = 1'b0;
  always #5 clk_hs = ~clk_hs;

  // Edges seen since reset release; the timestamp a trigger at the next edge must latch.
  always @(posedge clk_hs or negedge rst_hs_bar) begin
    if (!rst_hs_bar) cyc <= 0;
    else             cyc <= cyc + 1;
  end

  function automatic logic [31:0] ts_exp(input logic [31:0] v);
`ifdef FM_FREEZE_TS_EN
    return v;
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk_hs);
    #1;
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0; exp_ts = 32'd0;
    rst_hs_bar = 1'b0; in_data = '0; in_vld = 1'b0; arm = 1'b0; force_trig = 1'b0;
    release_frz = 1'b0; trig_value = 32'h0; trig_mask = 32'h0; post_trig_cnt = 16'd0;

    // Reset held with in_vld toggling
    for (int i = 0; i < 4; i++) begin
      in_vld = i[0]; in_data = 256'(i + 7);
      step();
      chk("rst_fm_vld", 256'(fm_vld), 256'd0);
      chk("rst_fm_data", fm_data, 256'd0);
    end
    chk("rst_freeze", 256'(freeze), 256'd0);
    chk("rst_state", 256'(state), 256'd0);
    chk("rst_trig_ts", 256'(trig_ts), 256'd0);
    rst_hs_bar = 1'b1;
    in_vld = 1'b1; in_data = 256'h1234;
    step();
    chk("post_rst_fm_vld1", 256'(fm_vld), 256'd1);
    chk("post_rst_fm_data", fm_data, 256'h1234);
    in_vld = 1'b0;
    step();
    chk("post_rst_fm_vld0", 256'(fm_vld), 256'd0);
    chk("post_rst_state", 256'(state), 256'd0);

    // Pattern match, 3-word post window; post_trig_cnt changed mid-window must not matter
    arm = 1'b1; trig_mask = 32'h0000_00FF; trig_value = 32'h0000_00A5; post_trig_cnt = 16'd3;
    step();
    arm = 1'b0;
    chk("armed", 256'(state), 256'd1);
    in_vld = 1'b1; in_data = 256'hDEAD_00A5;
    exp_ts = ts_exp(cyc);
    step();
    chk("match_post", 256'(state), 256'd2);
    chk("match_ts", 256'(trig_ts), 256'(exp_ts));
    post_trig_cnt = 16'd9;
    in_data = 256'h11; step();
    chk("post_w1", 256'(state), 256'd2);
    in_data = 256'h22; step();
    chk("post_w2", 256'(state), 256'd2);
    in_data = 256'h33; step();
    chk("post_w3_frozen", 256'(state), 256'd3);
    chk("post_w3_data", fm_data, 256'h33);
    chk("post_w3_nofrz", 256'(freeze), 256'd0);
    in_data = 256'h44; step();
    chk("freeze_rise", 256'(freeze), 256'd1);
    in_data = 256'h55; step();
    in_vld = 1'b0; release_frz = 1'b1;
    step();
    release_frz = 1'b0;
    chk("rel_idle", 256'(state), 256'd0);
    chk("rel_frz_hold", 256'(freeze), 256'd1);
    step();
    chk("rel_frz_fall", 256'(freeze), 256'd0);

    // Forced trigger with zero post count
    arm = 1'b1; post_trig_cnt = 16'd0; step(); arm = 1'b0;
    force_trig = 1'b1;
    exp_ts = ts_exp(cyc);
    step();
    force_trig = 1'b0;
    chk("force_frozen", 256'(state), 256'd3);
    chk("force_nofrz", 256'(freeze), 256'd0);
    chk("force_ts", 256'(trig_ts), 256'(exp_ts));
    step();
    chk("force_frz", 256'(freeze), 256'd1);
    release_frz = 1'b1; step(); release_frz = 1'b0;
    chk("force_rel", 256'(state), 256'd0);
    step();
    chk("force_rel_frz", 256'(freeze), 256'd0);

    // Abort in POST with remain = 2
    arm = 1'b1; trig_mask = 32'h0; post_trig_cnt = 16'd3; step(); arm = 1'b0;
    in_vld = 1'b1; in_data = 256'h77;
    exp_ts = ts_exp(cyc);
    step();
    step();
    chk("abort_pre", 256'(state), 256'd2);
    release_frz = 1'b1; step(); release_frz = 1'b0; in_vld = 1'b0;
    chk("abort_idle", 256'(state), 256'd0);
    chk("abort_nofrz0", 256'(freeze), 256'd0);
    step();
    chk("abort_nofrz1", 256'(freeze), 256'd0);

    // Match with release in the same cycle; arm/force in FROZEN ignored
    arm = 1'b1; trig_mask = 32'h0000_00FF; trig_value = 32'h0000_00A5; step(); arm = 1'b0;
    in_vld = 1'b1; in_data = 256'h00A5; release_frz = 1'b1;
    step();
    in_vld = 1'b0; release_frz = 1'b0;
    chk("trigrel_idle", 256'(state), 256'd0);
    chk("trigrel_ts", 256'(trig_ts), 256'(exp_ts));
    arm = 1'b1; post_trig_cnt = 16'd0; step(); arm = 1'b0;
    force_trig = 1'b1; exp_ts = ts_exp(cyc); step(); force_trig = 1'b0;
    arm = 1'b1; force_trig = 1'b1; step(); arm = 1'b0; force_trig = 1'b0;
    chk("arm_in_frozen", 256'(state), 256'd3);
    chk("force_in_frozen_ts", 256'(trig_ts), 256'(exp_ts));

    // Asynchronous reset while frozen
    in_vld = 1'b1; step();
    chk("pre_arst_frz", 256'(freeze), 256'd1);
    #2 rst_hs_bar = 1'b0;
    #1;
    chk("arst_freeze", 256'(freeze), 256'd0);
    chk("arst_state", 256'(state), 256'd0);
    chk("arst_fm_vld", 256'(fm_vld), 256'd0);
    in_vld = 1'b0;
    step();
    rst_hs_bar = 1'b1;

    // Trigger sampled on edge 101 after reset release: counter holds 100
    arm = 1'b1; post_trig_cnt = 16'd0; step(); arm = 1'b0;
    repeat (99) step();
    force_trig = 1'b1; step(); force_trig = 1'b0;
    chk("ts_state", 256'(state), 256'd3);
`ifdef FM_FREEZE_TS_EN
    chk("ts_100", 256'(trig_ts), 256'd100);
`else
    chk("ts_zero", 256'(trig_ts), 256'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
